// File: rtl/seq_pkg.sv
// Shared definitions for the serial 101-sequence path: serializer state
// encodings and default word width / idle line level.
package seq_pkg;

  // Serializer FSM encodings; code 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10
  } seq_state_t;

  localparam int   SEQ_WIDTH      = 8;
  localparam logic SEQ_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the 101-sequence detectors. Words arrive on a
// valid/ready handshake and leave MSB-first on `w`, one bit per clk, with
// gapless back-to-back framing when the next word is offered on the last bit.
// Optional build macro SER_PARITY_EN appends an even-parity bit to each frame.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = SEQ_WIDTH,
  parameter logic IDLE_LEVEL = SEQ_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
`ifndef SER_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
`endif

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_d, w_valid_d, last_d;
  logic             take;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // The registered `last` marks the final bit of a frame, which is exactly
  // the cycle a follow-on word may be accepted for gapless chaining.
  assign din_ready = !Reset && ((state_q == ST_IDLE) || last);
  assign take      = din_valid && din_ready;
  assign busy      = (state_q != ST_IDLE);

  // Next-state and next-output logic; a transfer always overrides with a fresh load
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    w_d       = IDLE_LEVEL;
    w_valid_d = 1'b0;
    last_d    = 1'b0;
`ifdef SER_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d     = cnt_q + CNT_W'(1);
          shift_d   = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
          w_d       = shift_q[WIDTH-2];
          w_valid_d = 1'b1;
`ifndef SER_PARITY_EN
          last_d    = (cnt_q == CNT_PENULT);
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_d   = ST_PAR;
          w_d       = par_q;
          w_valid_d = 1'b1;
          last_d    = 1'b1;
`else
          state_d   = ST_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take) begin
      state_d   = ST_SHIFT;
      shift_d   = din;
      cnt_d     = '0;
      w_d       = din[WIDTH-1];
      w_valid_d = 1'b1;
      last_d    = 1'b0;
`ifdef SER_PARITY_EN
      par_d     = ^din;
`endif
    end
  end

  // State, datapath and registered serial outputs; reset aborts any frame
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      w       <= IDLE_LEVEL;
      w_valid <= 1'b0;
      last    <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      w       <= w_d;
      w_valid <= w_valid_d;
      last    <= last_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
